ofdm_demapper: RTL and testbench

- Receive-side counterpart of the OFDM carrier mapper: consumes one frequency-domain OFDM symbol (FFT output, natural bin order, OFDM_SIZE bins per symbol) and splits it into a data-carrier stream for the QAM demodulator and a sign-corrected pilot stream for the channel estimator.
- Guard bins and the DC bin are discarded.
- Carrier layout is identical to the transmitter's:
  - mid = OFDM_SIZE/2-1
  - left = mid-Num_Carrier/2
  - right = mid+Num_Carrier/2
  - Pilot positions and polarities come from the shared pilot ROM.

---
 rtl/ofdm_demapper_if.sv | 45 ++++
 rtl/ofdm_demapper.sv | 181 ++++++++++++++++++
 tb/tb_ofdm_demapper.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ofdm_demapper_if.sv
// ofdm_demapper_if
// Streaming bundle between the FFT, the pilot ROM, the demapper and its two
// downstream consumers.
//   valid_in/sop_in/i_in/q_in/ready_out : FFT bin stream into the demapper
//   rom_addr -> index_pilot/sign_pilot  : pilot ROM lookup (registered ROM)
//   ready_in                            : shared downstream ready
//   i_data/q_data/valid_data/sos_data   : data carrier stream
//   i_pilot/q_pilot/valid_pilot         : sign-corrected pilot stream
//   sym_done/sym_cnt/sync_err           : symbol status
// slave is the demapper view, master is the surrounding-system view.
interface ofdm_demapper_if #(
  parameter int SYM_W = 16
);
  logic               valid_in;
  logic               sop_in;
  logic signed [15:0] i_in;
  logic signed [15:0] q_in;
  logic               ready_out;
  logic [10:0]        rom_addr;
  logic               index_pilot;
  logic               sign_pilot;
  logic               ready_in;
  logic signed [15:0] i_data;
  logic signed [15:0] q_data;
  logic               valid_data;
  logic               sos_data;
  logic signed [15:0] i_pilot;
  logic signed [15:0] q_pilot;
  logic               valid_pilot;
  logic               sym_done;
  logic [SYM_W-1:0]   sym_cnt;
  logic               sync_err;

  modport slave (
    input  valid_in, sop_in, i_in, q_in, index_pilot, sign_pilot, ready_in,
    output ready_out, rom_addr, i_data, q_data, valid_data, sos_data,
           i_pilot, q_pilot, valid_pilot, sym_done, sym_cnt, sync_err
  );

  modport master (
    output valid_in, sop_in, i_in, q_in, index_pilot, sign_pilot, ready_in,
    input  ready_out, rom_addr, i_data, q_data, valid_data, sos_data,
           i_pilot, q_pilot, valid_pilot, sym_done, sym_cnt, sync_err
  );
endinterface

// File: rtl/ofdm_demapper.sv
// ofdm_demapper
// Splits one natural-order FFT symbol into a data-carrier stream and a
// sign-corrected pilot stream, dropping guard bins and the DC bin.
// Ports:
//   clk   : rising-edge clock
//   res_n : asynchronous active-low reset
//   en    : global enable (low = stall)
//   bus   : ofdm_demapper_if.slave, see the interface file for signals
// Two-stage pipeline: stage 1 registers the accepted bin and its index while
// the external ROM looks it up; stage 2 classifies and drives the outputs.
module ofdm_demapper #(
  parameter int OFDM_SIZE   = 1024,
  parameter int Num_Carrier = 824,
  parameter int SYM_W       = 16
) (
  input  logic clk,
  input  logic res_n,
  input  logic en,
  ofdm_demapper_if.slave bus
);

  localparam int MID   = OFDM_SIZE / 2 - 1;
  localparam int LEFT  = MID - Num_Carrier / 2;
  localparam int RIGHT = MID + Num_Carrier / 2;
  localparam int LAST  = OFDM_SIZE - 1;

  localparam logic [10:0] MID_IDX   = 11'(MID);
  localparam logic [10:0] LEFT_IDX  = 11'(LEFT);
  localparam logic [10:0] RIGHT_IDX = 11'(RIGHT);
  localparam logic [10:0] LAST_IDX  = 11'(LAST);

  logic               advance;
  logic               accept;
  logic [10:0]        idx_cur;
  logic [10:0]        cnt_next;

  logic [10:0]        cnt_reg;
  logic               s1_valid_reg;
  logic signed [15:0] s1_i_reg;
  logic signed [15:0] s1_q_reg;
  logic [10:0]        s1_idx_reg;

  logic               rom_fresh_reg;
  logic               rom_pilot_hold_reg;
  logic               rom_sign_hold_reg;

  logic signed [15:0] i_data_reg;
  logic signed [15:0] q_data_reg;
  logic               valid_data_reg;
  logic               sos_data_reg;
  logic               sos_pending_reg;
  logic signed [15:0] i_pilot_reg;
  logic signed [15:0] q_pilot_reg;
  logic               valid_pilot_reg;
  logic               sym_done_reg;
  logic [SYM_W-1:0]   sym_cnt_reg;
  logic               sync_err_reg;

  logic               pilot_flag;
  logic               pilot_neg;
  logic               inband;
  logic               is_pilot;
  logic               is_data;
  logic               is_last;

  function automatic logic signed [15:0] neg_sat(input logic signed [15:0] x);
    return (x == 16'sh8000) ? 16'sh7fff : -x;
  endfunction

  assign advance = en & bus.ready_in;
  assign accept  = bus.valid_in & advance;

  // sop forces index 0 regardless of where the counter stands.
  assign idx_cur  = bus.sop_in ? 11'd0 : cnt_reg;
  assign cnt_next = (idx_cur == LAST_IDX) ? 11'd0 : idx_cur + 11'd1;

  assign bus.ready_out = advance;
  assign bus.rom_addr  = idx_cur;

  // The ROM answer is only live in the cycle right after the lookup; if the
  // pipeline stalls then, the answer is parked and used when stage 2 runs.
  always_comb begin
    pilot_flag = rom_pilot_hold_reg;
    pilot_neg  = rom_sign_hold_reg;
    if (rom_fresh_reg) begin
      pilot_flag = bus.index_pilot;
      pilot_neg  = bus.sign_pilot;
    end
  end

  assign inband   = (s1_idx_reg >= LEFT_IDX) && (s1_idx_reg <= RIGHT_IDX) &&
                    (s1_idx_reg != MID_IDX);
  assign is_pilot = s1_valid_reg & inband & pilot_flag;
  assign is_data  = s1_valid_reg & inband & ~pilot_flag;
  assign is_last  = s1_valid_reg && (s1_idx_reg == LAST_IDX);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      cnt_reg            <= '0;
      s1_valid_reg       <= 1'b0;
      s1_i_reg           <= '0;
      s1_q_reg           <= '0;
      s1_idx_reg         <= '0;
      rom_fresh_reg      <= 1'b0;
      rom_pilot_hold_reg <= 1'b0;
      rom_sign_hold_reg  <= 1'b0;
      i_data_reg         <= '0;
      q_data_reg         <= '0;
      valid_data_reg     <= 1'b0;
      sos_data_reg       <= 1'b0;
      sos_pending_reg    <= 1'b0;
      i_pilot_reg        <= '0;
      q_pilot_reg        <= '0;
      valid_pilot_reg    <= 1'b0;
      sym_done_reg       <= 1'b0;
      sym_cnt_reg        <= '0;
      sync_err_reg       <= 1'b0;
    end else begin
      rom_fresh_reg <= accept;
      if (rom_fresh_reg) begin
        rom_pilot_hold_reg <= bus.index_pilot;
        rom_sign_hold_reg  <= bus.sign_pilot;
      end

      if (advance) begin
        // Stage 1
        s1_valid_reg <= accept;
        if (accept) begin
          s1_i_reg   <= bus.i_in;
          s1_q_reg   <= bus.q_in;
          s1_idx_reg <= idx_cur;
          cnt_reg    <= cnt_next;
        end
        sync_err_reg <= accept & bus.sop_in & (cnt_reg != 11'd0);

        // Stage 2
        valid_data_reg  <= is_data;
        valid_pilot_reg <= is_pilot;
        sos_data_reg    <= is_data & sos_pending_reg;
        if (is_data) begin
          i_data_reg <= s1_i_reg;
          q_data_reg <= s1_q_reg;
        end
        if (is_pilot) begin
          i_pilot_reg <= pilot_neg ? neg_sat(s1_i_reg) : s1_i_reg;
          q_pilot_reg <= pilot_neg ? neg_sat(s1_q_reg) : s1_q_reg;
        end
        // Any low-guard bin arms the start-of-symbol flag, so realigned or
        // silently wrapped symbols still mark their first data carrier.
        if (s1_valid_reg) begin
          if (s1_idx_reg < LEFT_IDX) begin
            sos_pending_reg <= 1'b1;
          end else if (is_data) begin
            sos_pending_reg <= 1'b0;
          end
        end

        sym_done_reg <= is_last;
        if (is_last) begin
          sym_cnt_reg <= sym_cnt_reg + SYM_W'(1);
        end
      end else begin
        // Status strobes are single-cycle events, not held stream data.
        sym_done_reg <= 1'b0;
        sync_err_reg <= 1'b0;
      end
    end
  end

  assign bus.i_data      = i_data_reg;
  assign bus.q_data      = q_data_reg;
  assign bus.valid_data  = valid_data_reg;
  assign bus.sos_data    = sos_data_reg;
  assign bus.i_pilot     = i_pilot_reg;
  assign bus.q_pilot     = q_pilot_reg;
  assign bus.valid_pilot = valid_pilot_reg;
  assign bus.sym_done    = sym_done_reg;
  assign bus.sym_cnt     = sym_cnt_reg;
  assign bus.sync_err    = sync_err_reg;

endmodule

// File: tb/tb_ofdm_demapper.sv
module tb_ofdm_demapper;

  typedef struct {
    bit                 pilot;
    logic signed [15:0] i;
    logic signed [15:0] q;
    bit                 sos;
  } exp_t;

  logic clk;
  logic res_n;
  logic en;
  ofdm_demapper_if #(.SYM_W(16)) bus ();

  ofdm_demapper #(.OFDM_SIZE(1024), .Num_Carrier(824), .SYM_W(16)) dut (
    .clk   (clk),
    .res_n (res_n),
    .en    (en),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks;
  int   failures;
  int   cyc;
  int   rom_mode;
  int   val_mode;
  int   data_cnt;
  int   pilot_cnt;
  int   done_cnt;
  int   err_cnt;
  int   done_cyc;
  int   last_acc_cyc;
  bit   sos_pend;
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Pilot ROM model. Mode 1: every 8th bin from 99, sign alternating.
  // Mode 2: a single negative pilot at bin 200.
  function automatic bit rom_pilot(input int a);
    if (rom_mode == 1) return (a >= 99) && (a <= 923) && (((a - 99) % 8) == 0);
    if (rom_mode == 2) return a == 200;
    return 1'b0;
  endfunction

  function automatic bit rom_sign(input int a);
    if (rom_mode == 1) return (((a - 99) / 8) % 2) == 1;
    if (rom_mode == 2) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    bus.index_pilot <= rom_pilot(int'(bus.rom_addr));
    bus.sign_pilot  <= rom_sign(int'(bus.rom_addr));
  end

  function automatic logic signed [15:0] neg16(input logic signed [15:0] x);
    return (x == -16'sd32768) ? 16'sd32767 : -x;
  endfunction

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Expected-response model: push what bin idx must produce at the output.
  task automatic push_expect(input int idx, input logic signed [15:0] iv, input logic signed [15:0] qv);
    exp_t e;
    if (idx < 99) sos_pend = 1'b1;
    if (idx >= 99 && idx <= 923 && idx != 511) begin
      e.pilot = rom_pilot(idx);
      if (e.pilot) begin
        e.i   = rom_sign(idx) ? neg16(iv) : iv;
        e.q   = rom_sign(idx) ? neg16(qv) : qv;
        e.sos = 1'b0;
      end else begin
        e.i      = iv;
        e.q      = qv;
        e.sos    = sos_pend;
        sos_pend = 1'b0;
      end
      exp_q.push_back(e);
    end
  endtask

  // Monitor: pops one expectation per consumed output beat.
  always @(negedge clk) begin
    if (res_n) begin
      if (bus.sym_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.sync_err) err_cnt++;
      if (bus.ready_in && (bus.valid_data || bus.valid_pilot)) begin
        exp_t e;
        if (bus.valid_data && bus.valid_pilot)
          check(1'b0, "valid_overlap", 1, 0);
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_beat", bus.valid_pilot ? 1 : 0, -1);
        end else begin
          e = exp_q.pop_front();
          if (bus.valid_pilot) begin
            pilot_cnt++;
            checks++;
            if (!e.pilot || bus.i_pilot !== e.i || bus.q_pilot !== e.q) begin
              failures++;
              $display("FAIL pilot_beat actual=pilot(%0d,%0d) required=%s(%0d,%0d)",
                       bus.i_pilot, bus.q_pilot, e.pilot ? "pilot" : "data", e.i, e.q);
            end
          end else begin
            data_cnt++;
            checks++;
            if (e.pilot || bus.i_data !== e.i || bus.q_data !== e.q || bus.sos_data !== e.sos) begin
              failures++;
              $display("FAIL data_beat actual=data(%0d,%0d,sos=%0d) required=%s(%0d,%0d,sos=%0d)",
                       bus.i_data, bus.q_data, bus.sos_data, e.pilot ? "pilot" : "data",
                       e.i, e.q, e.sos);
            end
          end
        end
      end
    end
  end

  task automatic send_bin(input bit sop, input int idx, input logic signed [15:0] iv, input logic signed [15:0] qv);
    int guard;
    bus.valid_in = 1'b1;
    bus.sop_in   = sop;
    bus.i_in     = iv;
    bus.q_in     = qv;
    guard = 0;
    forever begin
      @(negedge clk);
      if (bus.ready_out) break;
      guard++;
      if (guard > 50) begin
        check(1'b0, "accept_timeout", 0, 1);
        break;
      end
    end
    push_expect(idx, iv, qv);
    @(posedge clk);
    #1;
    last_acc_cyc = cyc;
    bus.valid_in = 1'b0;
    bus.sop_in   = 1'b0;
  endtask

  task automatic do_stall();
    logic               vd, vp;
    logic signed [15:0] id, ip;
    bus.ready_in = 1'b0;
    @(negedge clk);
    vd = bus.valid_data;
    vp = bus.valid_pilot;
    id = bus.i_data;
    ip = bus.i_pilot;
    repeat (5) begin
      @(negedge clk);
      check(bus.ready_out == 1'b0, "stall_ready_out", bus.ready_out, 0);
      check(bus.valid_data == vd && bus.i_data == id && bus.valid_pilot == vp && bus.i_pilot == ip,
            "stall_frozen", bus.i_data, id);
    end
    @(posedge clk);
    #1;
    bus.ready_in = 1'b1;
  endtask

  task automatic send_symbol(input int nbins, input int stall_bin);
    logic signed [15:0] iv, qv;
    for (int idx = 0; idx < nbins; idx++) begin
      if (idx == stall_bin) do_stall();
      case (val_mode)
        1: begin iv = 16'sd1000; qv = 16'sd1000; end
        2: begin
          iv = (idx == 200) ? -16'sd32768 : 16'(idx);
          qv = (idx == 200) ? 16'sd5 : -16'(idx);
        end
        default: begin iv = 16'(idx); qv = -16'(idx); end
      endcase
      send_bin(idx == 0, idx, iv, qv);
    end
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
    check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
  endtask

  task automatic clear_counts();
    data_cnt = 0; pilot_cnt = 0; done_cnt = 0; err_cnt = 0;
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; rom_mode = 0; val_mode = 0;
    sos_pend = 1'b0; done_cyc = 0; last_acc_cyc = 0;
    clear_counts();
    en = 1'b1;
    res_n = 1'b0;
    bus.valid_in = 1'b0; bus.sop_in = 1'b0; bus.i_in = '0; bus.q_in = '0;
    bus.ready_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check(bus.valid_data == 0 && bus.valid_pilot == 0 && bus.sos_data == 0, "reset_valids", bus.valid_data, 0);
    check(bus.i_data == 0 && bus.q_data == 0 && bus.i_pilot == 0 && bus.q_pilot == 0, "reset_values", bus.i_data, 0);
    check(bus.sym_cnt == 0 && bus.sym_done == 0 && bus.sync_err == 0, "reset_status", bus.sym_cnt, 0);
    res_n = 1'b1;
    @(posedge clk);
    #1;
    check(bus.rom_addr == 0, "reset_rom_addr", bus.rom_addr, 0);
    check(bus.ready_out == 1'b1, "ready_out_idle", bus.ready_out, 1);

    // Plain symbol, no pilots.
    $display("test plain symbol");
    clear_counts();
    send_symbol(1024, -1);
    drain();
    check(data_cnt == 824, "plain_data_cnt", data_cnt, 824);
    check(pilot_cnt == 0, "plain_pilot_cnt", pilot_cnt, 0);
    check(done_cnt == 1, "plain_sym_done", done_cnt, 1);
    check(done_cyc - last_acc_cyc == 1, "sym_done_timing", done_cyc - last_acc_cyc, 1);
    check(bus.sym_cnt == 1, "plain_sym_cnt", bus.sym_cnt, 1);
    check(err_cnt == 0, "plain_no_sync_err", err_cnt, 0);

    // Pilot comb with alternating sign.
    $display("test pilot comb");
    clear_counts();
    rom_mode = 1; val_mode = 1;
    send_symbol(1024, -1);
    drain();
    check(pilot_cnt == 104, "comb_pilot_cnt", pilot_cnt, 104);
    check(data_cnt == 720, "comb_data_cnt", data_cnt, 720);
    check(bus.sym_cnt == 2, "comb_sym_cnt", bus.sym_cnt, 2);

    // Saturating negation of -32768.
    $display("test pilot saturation");
    clear_counts();
    rom_mode = 2; val_mode = 2;
    send_symbol(1024, -1);
    drain();
    check(pilot_cnt == 1, "sat_pilot_cnt", pilot_cnt, 1);
    check(data_cnt == 823, "sat_data_cnt", data_cnt, 823);

    // Downstream stall mid-symbol.
    $display("test stall");
    clear_counts();
    rom_mode = 0; val_mode = 0;
    send_symbol(1024, 400);
    drain();
    check(data_cnt == 824, "stall_data_cnt", data_cnt, 824);
    check(bus.sym_cnt == 4, "stall_sym_cnt", bus.sym_cnt, 4);

    // Early sop at bin 300.
    $display("test early sop");
    clear_counts();
    send_symbol(300, -1);
    send_symbol(1024, -1);
    drain();
    check(err_cnt == 1, "early_sop_sync_err", err_cnt, 1);
    check(done_cnt == 1, "early_sop_sym_done", done_cnt, 1);
    check(data_cnt == 201 + 824, "early_sop_data_cnt", data_cnt, 1025);
    check(bus.sym_cnt == 5, "early_sop_sym_cnt", bus.sym_cnt, 5);

    // Asynchronous reset mid-symbol.
    $display("test reset mid-symbol");
    clear_counts();
    send_symbol(500, -1);
    res_n = 1'b0;
    #1;
    check(bus.valid_data == 0 && bus.i_data == 0 && bus.q_data == 0, "midreset_data", bus.i_data, 0);
    check(bus.sym_cnt == 0 && bus.sym_done == 0 && bus.valid_pilot == 0, "midreset_status", bus.sym_cnt, 0);
    exp_q.delete();
    sos_pend = 1'b0;
    @(posedge clk);
    #1;
    res_n = 1'b1;
    clear_counts();
    send_symbol(1024, -1);
    drain();
    check(data_cnt == 824, "postreset_data_cnt", data_cnt, 824);
    check(bus.sym_cnt == 1, "postreset_sym_cnt", bus.sym_cnt, 1);
    check(err_cnt == 0, "postreset_no_sync_err", err_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule
